// File: rtl/maxpool_2x2_pkg.sv
// Shared constants and helpers for the 2x2 max-pooling stage.
//   DEF_WORD_SIZE : global pixel width used by the conv/ReLU/pool pipeline.
//   ptr_width()   : address width for an n-entry array, never below 1 bit.
package maxpool_2x2_pkg;

    localparam int DEF_WORD_SIZE = 16;

    // A 1-entry array still needs a 1-bit address port.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool_2x2_line_buf.sv
// pool_line_buf: holds the horizontal pair maxima of the current even row.
// No reset. Every entry is written on an even row before the following odd
// row reads it.
//   clk   : write clock
//   we    : write enable, with waddr / wdata
//   raddr : combinational read address, result on rdata
module pool_line_buf #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int PW        = 2
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PW-1:0]        waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [PW-1:0]        raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2, stride-2 signed max pooling on a row-major
// pixel stream (one pixel per cycle at most, no backpressure).
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   DI_valid   : DI carries a pixel this cycle
//   DI         : signed pixel
//   DO_valid   : one-cycle pulse, DO carries a pooled maximum
//   DO         : pooled maximum, held between pulses
//   frame_done : pulses together with the last DO_valid of a frame
//
// Dataflow: even columns park the pixel in h_q. Odd columns form the
// horizontal pair max; on even rows it goes to the line buffer, on odd rows
// it is combined with the stored pair from the row above and emitted.
module maxpool_2x2
    import maxpool_2x2_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 DI_valid,
    input  logic [WORD_SIZE-1:0] DI,
    output logic                 DO_valid,
    output logic [WORD_SIZE-1:0] DO,
    output logic                 frame_done
);

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_params
        $error("maxpool_2x2: IMG_W and IMG_H must be even and >= 2");
    end

    localparam int CW = ptr_width(IMG_W);
    localparam int RW = ptr_width(IMG_H);
    localparam int PW = ptr_width(IMG_W / 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    function automatic logic [WORD_SIZE-1:0] smax(input logic [WORD_SIZE-1:0] a,
                                                  input logic [WORD_SIZE-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WORD_SIZE-1:0] h_q, h_d;
    logic [WORD_SIZE-1:0] do_q, do_d;
    logic                 do_valid_q, do_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [WORD_SIZE-1:0] hm;
    logic                 lb_we;
    logic [PW-1:0]        lb_addr;
    logic [WORD_SIZE-1:0] lb_rdata;

    // Pair index within the row; same slot for the even-row write and
    // the odd-row read.
    assign lb_addr = PW'(col_q >> 1);
    assign hm      = smax(h_q, DI);

    pool_line_buf #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (IMG_W / 2),
        .PW        (PW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hm),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        do_d         = do_q;
        do_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (DI_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                h_d = DI;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                do_d         = smax(lb_rdata, hm);
                do_valid_d   = 1'b1;
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            do_q         <= '0;
            do_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            do_q         <= do_d;
            do_valid_q   <= do_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign DO         = do_q;
    assign DO_valid   = do_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Bench for maxpool_2x2 on a 4x4 image. Frames with hand-computed window
// maxima sit in a table; run_frame streams a frame (optionally with idle
// cycles between pixels) and checks every cycle's outputs. Reset mid-frame
// and back-to-back frames are hand-written sequences.
module tb_maxpool_2x2;

    localparam int W  = 16;
    localparam int IW = 4;
    localparam int IH = 4;

    logic         clk;
    logic         rst;
    logic         di_valid;
    logic [W-1:0] di;
    logic         do_valid;
    logic [W-1:0] do_data;
    logic         frame_done;

    maxpool_2x2 #(.WORD_SIZE(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk        (clk),
        .rst        (rst),
        .DI_valid   (di_valid),
        .DI         (di),
        .DO_valid   (do_valid),
        .DO         (do_data),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][W-1:0] pix;   // row-major pixels
        logic [3:0][W-1:0]  exp;   // window maxima in row-major window order
    } frame_t;

    frame_t       frames [4];
    int           checks;
    int           errors;
    int           fd_count;
    logic [W-1:0] last_do;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        di_valid = 1'b0;
        di       = '0;
        rst      = 1'b1;
        #2;
        check("rst_do_valid", {15'd0, do_valid}, 16'd0);
        check("rst_do", do_data, 16'd0);
        check("rst_frame_done", {15'd0, frame_done}, 16'd0);
        last_do = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver + per-cycle checks ----------------
    task automatic run_frame(input int f, input bit gaps, input int npix);
        int k;
        int pulses;
        k      = 0;
        pulses = 0;
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            di_valid = 1'b1;
            di       = frames[f].pix[i];
            @(posedge clk);
            #1;
            if (do_valid) pulses++;
            if (frame_done) fd_count++;
            if (((i / IW) % 2 == 1) && ((i % IW) % 2 == 1)) begin
                check($sformatf("f%0d_px%0d_valid", f, i), {15'd0, do_valid}, 16'd1);
                check($sformatf("f%0d_px%0d_do", f, i), do_data, frames[f].exp[k]);
                check($sformatf("f%0d_px%0d_fdone", f, i), {15'd0, frame_done},
                      (k == 3) ? 16'd1 : 16'd0);
                last_do = frames[f].exp[k];
                k++;
            end else begin
                check($sformatf("f%0d_px%0d_novalid", f, i), {15'd0, do_valid}, 16'd0);
                check($sformatf("f%0d_px%0d_nofdone", f, i), {15'd0, frame_done}, 16'd0);
                check($sformatf("f%0d_px%0d_hold", f, i), do_data, last_do);
            end
            if (gaps) begin
                @(negedge clk);
                di_valid = 1'b0;
                di       = 16'hDEAD;
                @(posedge clk);
                #1;
                if (do_valid) pulses++;
                check($sformatf("f%0d_gap%0d_novalid", f, i), {15'd0, do_valid}, 16'd0);
                check($sformatf("f%0d_gap%0d_hold", f, i), do_data, last_do);
            end
        end
        if (npix == IW * IH) begin
            check($sformatf("f%0d_pulse_count", f), W'(pulses), 16'd4);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        fd_count = 0;
        last_do  = '0;
        rst      = 1'b1;
        di_valid = 1'b0;
        di       = '0;

        // frame 0: ramp 0..15 -> 5, 7, 13, 15
        for (int i = 0; i < 16; i++) frames[0].pix[i] = W'(i);
        frames[0].exp = {16'd15, 16'd13, 16'd7, 16'd5};
        // frame 1: signed. Window 0 {-3,-1,-7,-2} -> -1; window 1 {-1,0,0,0} -> 0
        frames[1].pix = '0;
        frames[1].pix[0] = 16'hFFFD;
        frames[1].pix[1] = 16'hFFFF;
        frames[1].pix[4] = 16'hFFF9;
        frames[1].pix[5] = 16'hFFFE;
        frames[1].pix[2] = 16'hFFFF;
        frames[1].exp = {16'd0, 16'd0, 16'd0, 16'hFFFF};
        // frame 2: descending 15..0, maxima at window top-left -> 15, 13, 7, 5
        for (int i = 0; i < 16; i++) frames[2].pix[i] = W'(15 - i);
        frames[2].exp = {16'd5, 16'd7, 16'd13, 16'd15};
        // frame 3: all ties
        for (int i = 0; i < 16; i++) frames[3].pix[i] = 16'd9;
        frames[3].exp = {16'd9, 16'd9, 16'd9, 16'd9};

        apply_reset();

        // ramp, back-to-back
        run_frame(0, 1'b0, 16);
        // ramp with idle cycles between pixels
        run_frame(0, 1'b1, 16);
        // signed compare
        run_frame(1, 1'b0, 16);

        // reset after 6 pixels, then a full frame must restart at (0,0)
        run_frame(0, 1'b0, 6);
        apply_reset();
        run_frame(0, 1'b0, 16);

        // back-to-back frames: ramp, descending, ties
        fd_count = 0;
        run_frame(0, 1'b0, 16);
        run_frame(2, 1'b0, 16);
        check("b2b_frame_done_count", W'(fd_count), 16'd2);
        run_frame(3, 1'b0, 16);

        @(negedge clk);
        di_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the ReLU stage.
- Consumes the ReLU's DO_valid/DO pixel stream, row-major, one pixel per cycle maximum, no backpressure.
- Emits one pooled word per 2x2 window and feeds the next layer's input buffer.
- Keeps a half-width line buffer holding the horizontal pair maxima of the current even row.

Parameters:
WORD_SIZE, 16, pixel width in bits; the global value comes from the shared define header.
IMG_W, 8, feature-map width in pixels; must be even and >= 2.
IMG_H, 8, feature-map height in pixels; must be even and >= 2.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
rst  input  1  asynchronous, active-high reset.
DI_valid  input  1  DI carries a pixel this cycle.
DI  input  WORD_SIZE  pixel, signed two's complement.
DO_valid  output  1  one-cycle pulse; DO carries a pooled result.
DO  output  WORD_SIZE  pooled maximum, signed.
frame_done  output  1  one-cycle pulse, coincident with the last DO_valid of a frame.

Behaviour:
- Reset (asynchronous, active-high): col=0, row=0, pair register h=0, DO=0, DO_valid=0, frame_done=0.
- Line-buffer contents are not reset. Every entry is written before it is read, and verification must not depend on its reset contents.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on DI_valid=1.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the pixel at (IMG_H-1, IMG_W-1).
- Even col, DI_valid: h <= DI.
- Odd col, DI_valid: hm = max(h, DI), a combinational signed compare.
  - Even row: linebuf[col>>1] <= hm. No output.
  - Odd row: DO <= max(linebuf[col>>1], hm), DO_valid <= 1.
- Latency: DO_valid rises on the clock edge after the bottom-right pixel of a window is accepted (1 cycle).
- Throughput: back-to-back pixels are accepted every cycle with no stalls. Output rate is at most one result per 2 cycles.
- Output count: (IMG_W/2)*(IMG_H/2) results per frame, emitted in row-major window order.
- frame_done <= 1 in the same cycle as the DO_valid for window (IMG_H/2-1, IMG_W/2-1). It is 0 otherwise.
- DI_valid=0 gaps: all state is held, DO_valid=0, and DO holds its last value.
- Ties: equal operands produce that value.
- Compare is signed. The ReLU never emits negatives, but the block must stay correct if the ReLU is bypassed.
- Reset mid-frame: the partial frame is discarded with no output. The next accepted pixel is (0,0).
- Frames run back-to-back with no gap cycles required between them.
- Bad parameters: elaboration fails (generate-time error) if IMG_W or IMG_H is odd or < 2.
- Pointer width for the line buffer: clog2(IMG_W/2), minimum 1.

Decomposition:
- WORD_SIZE comes from the shared define header. No new typedefs.
- A local signed-max function is used for both compare points.
- One sub-module, pool_line_buf: IMG_W/2 x WORD_SIZE register array.
  - Synchronous write (we, waddr, wdata).
  - Combinational read (raddr, rdata).
  - No reset.
- Counters, pair register and output registers stay in maxpool_2x2.

Test Plan:
1. IMG_W=IMG_H=4; feed ramp 0..15 back-to-back -> DO = 5, 7, 13, 15, each one cycle after pixels 5, 7, 13, 15 are accepted; exactly 4 DO_valid pulses; frame_done with the DO=15 pulse.
2. Same ramp with DI_valid toggling 1,0,1,0 -> identical DO sequence 5, 7, 13, 15; DO holds its value between pulses; no extra pulses.
3. Signed: first window {-3, -1, -7, -2} (0xFFFD, 0xFFFF, 0xFFF9, 0xFFFE), other pixels 0 -> first DO = 0xFFFF; window {-1, 0, 0, 0} -> DO = 0.
4. Assert rst after 6 pixels of a frame, then send a full ramp frame -> no DO_valid before pixel 5 of the new frame; outputs exactly as in test 1.
5. Two frames back-to-back, second frame with each window max at its top-left (e.g. descending 15..0) -> second frame DO = 15, 13, 7, 5; frame_done pulses twice; ties (all pixels 9) -> DO = 9 for every window.
